spi_sclk_engine: RTL

Parametrised SPI serial-clock engine, successor to the fixed-rate SPI clock generator. Produces SCLK with a runtime-programmable half-period, all four SPI modes (CPOL/CPHA), and a fixed-length burst of bits per transfer. It also produces single-cycle sample/shift strobes for the shift-register datapath and a start/busy/done handshake for the SPI master controller.

---
 rtl/spi_sclk_engine.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/spi_sclk_engine.sv
// ============================================================================
// spi_sclk_engine : SPI SCLK generator with programmable half-period, CPOL/CPHA
//                   and a fixed bit burst; optional abort via SPI_SCLK_ABORT_EN
// Revision 1.0
// ============================================================================
`default_nettype none

module spi_sclk_engine #(
  parameter int DIV_W = 9,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [DIV_W-1:0] half_period,
  input  logic [CNT_W-1:0] num_bits,
  input  logic             cpol,
  input  logic             cpha,
  input  logic             start,
`ifdef SPI_SCLK_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic             sclk,
  output logic             sample_t,
  output logic             shift_t
);

  localparam logic [DIV_W-1:0] C_DIV_ONE = DIV_W'(1);
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] hp_q, hp_d;
  logic [CNT_W-1:0] bit_q, bit_d;
  logic [CNT_W-1:0] nb_q, nb_d;
  logic             trail_q, trail_d;
  logic             cpol_q, cpol_d;
  logic             cpha_q, cpha_d;
  logic             sclk_q, sclk_d;
  logic             done_q, done_d;

  logic             w_abort;
  logic             w_edge;
  logic             w_last;

`ifdef SPI_SCLK_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // An abort in RUN swallows any edge that would have fired in the same cycle.
  assign w_edge   = (state_q == ST_RUN) && !w_abort && (div_q == (hp_q - C_DIV_ONE));
  assign w_last   = trail_q && (bit_q == (nb_q - C_CNT_ONE));
  assign sample_t = w_edge && (trail_q == cpha_q);
  assign shift_t  = w_edge && (trail_q != cpha_q);
  assign busy     = (state_q == ST_RUN);
  assign done     = done_q;
  assign sclk     = sclk_q;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    hp_d    = hp_q;
    bit_d   = bit_q;
    nb_d    = nb_q;
    trail_d = trail_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    sclk_d  = sclk_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        sclk_d  = cpol;
        div_d   = '0;
        bit_d   = '0;
        trail_d = 1'b0;
        if (start && (half_period != '0) && (num_bits != '0)) begin
          state_d = ST_RUN;
          hp_d    = half_period;
          nb_d    = num_bits;
          cpol_d  = cpol;
          cpha_d  = cpha;
        end
      end

      ST_RUN: begin
        if (w_abort) begin
          state_d = ST_IDLE;
          sclk_d  = cpol_q;
          div_d   = '0;
          bit_d   = '0;
          trail_d = 1'b0;
        end else if (w_edge) begin
          div_d   = '0;
          trail_d = ~trail_q;
          sclk_d  = ~sclk_q;
          if (w_last) begin
            state_d = ST_IDLE;
            sclk_d  = cpol_q;
            bit_d   = '0;
            done_d  = 1'b1;
          end else if (trail_q) begin
            bit_d = bit_q + C_CNT_ONE;
          end
        end else begin
          div_d = div_q + C_DIV_ONE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      hp_q    <= '0;
      bit_q   <= '0;
      nb_q    <= '0;
      trail_q <= 1'b0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      sclk_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      hp_q    <= hp_d;
      bit_q   <= bit_d;
      nb_q    <= nb_d;
      trail_q <= trail_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      sclk_q  <= sclk_d;
      done_q  <= done_d;
    end
  end

endmodule

`default_nettype wire
